// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result requesters, decode's hazard check and
// the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic [4:0]        alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [4:0]        mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              RegWrite;
  logic [4:0]        WriteRegAddr;
  logic [DATA_W-1:0] WriteData;

  logic              issue_valid;
  logic [4:0]        issue_addr;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              rs1_pending;
  logic              rs2_pending;

  // The arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output RegWrite, WriteRegAddr, WriteData,
    input  issue_valid, issue_addr, rs1_addr, rs2_addr,
    output rs1_pending, rs2_pending
  );

  // Requesters, decode and the register file together.
  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  RegWrite, WriteRegAddr, WriteData,
    output issue_valid, issue_addr, rs1_addr, rs2_addr,
    input  rs1_pending, rs2_pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load writebacks and
// tracks in-flight destination registers for read-after-write hazard checks.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [31:0]       pending_q, pending_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              alu_win, mem_win;
  logic              alu_acc, mem_acc;

  // Counts lost cycles but never beyond the limit at which ALU is forced through.
  function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                             input logic       waiting);
    if (!waiting)
      return 4'd0;
    else if (cnt >= LIMIT)
      return LIMIT;
    else
      return cnt + 4'd1;
  endfunction

  // Grant depends only on the valids and the starvation count, never on data.
  always_comb begin
    alu_win = bus.alu_valid && (!bus.mem_valid || (starve_cnt_q == LIMIT));
    mem_win = bus.mem_valid && !alu_win;
    alu_acc = reset && alu_win;
    mem_acc = reset && mem_win;
  end

  assign bus.alu_ready = alu_acc;
  assign bus.mem_ready = mem_acc;

  always_comb begin
    starve_cnt_d = starve_next(starve_cnt_q, bus.alu_valid && !alu_acc);
  end

  // Output register: address and data hold whenever nothing is granted.
  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (alu_acc) begin
      wr_addr_d   = bus.alu_addr;
      wr_data_d   = bus.alu_data;
      reg_write_d = (bus.alu_addr != 5'd0);
    end else if (mem_acc) begin
      wr_addr_d   = bus.mem_addr;
      wr_data_d   = bus.mem_data;
      reg_write_d = (bus.mem_addr != 5'd0);
    end
  end

  // A new issue to the register being committed keeps it pending: a younger
  // producer is still in flight.
  always_comb begin
    pending_d = pending_q;
    if (alu_acc)
      pending_d[bus.alu_addr] = 1'b0;
    if (mem_acc)
      pending_d[bus.mem_addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != 5'd0))
      pending_d[bus.issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
      pending_q    <= '0;
      reg_write_q  <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.RegWrite     = reg_write_q;
  assign bus.WriteRegAddr = wr_addr_q;
  assign bus.WriteData    = wr_data_q;

  assign bus.rs1_pending  = pending_q[bus.rs1_addr];
  assign bus.rs2_pending  = pending_q[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at grant
// time and a negedge monitor checks every RegWrite pulse against the queue.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(32)) bus();

  regfile_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write (t=%0t)",
                 bus.WriteRegAddr, bus.WriteData, $time);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, bus.WriteRegAddr}, {27'd0, e[36:32]});
        chk("wr_data", bus.WriteData, e[31:0]);
      end
      rf[bus.WriteRegAddr] = bus.WriteData;
    end
  end

  // Checks the hand-expected grant mid-cycle, queues the resulting write, and
  // returns just after the accept edge so the caller can drive the next cycle.
  task automatic expect_grant(input bit a_rdy, input bit m_rdy, input string tag);
    @(negedge clk); #1;
    chk({tag, "_alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, a_rdy});
    chk({tag, "_mem_ready"}, {31'd0, bus.mem_ready}, {31'd0, m_rdy});
    if (a_rdy && bus.alu_addr != 5'd0) exp_q.push_back({bus.alu_addr, bus.alu_data});
    if (m_rdy && bus.mem_addr != 5'd0) exp_q.push_back({bus.mem_addr, bus.mem_data});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset           = 1'b0;
    bus.alu_valid   = 1'b1;  bus.alu_addr = 5'd3; bus.alu_data = 32'hA3;
    bus.mem_valid   = 1'b1;  bus.mem_addr = 5'd4; bus.mem_data = 32'hB4;
    bus.issue_valid = 1'b0;  bus.issue_addr = 5'd0;
    bus.rs1_addr    = 5'd0;  bus.rs2_addr = 5'd0;

    // Reset held with both requesters valid.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_regwrite",  {31'd0, bus.RegWrite}, 32'd0);
    chk("rst_wr_addr",   {27'd0, bus.WriteRegAddr}, 32'd0);
    chk("rst_wr_data",   bus.WriteData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_grant(1'b0, 1'b1, "post_rst");
    bus.mem_valid = 1'b0;
    expect_grant(1'b1, 1'b0, "post_rst_alu");
    bus.alu_valid = 1'b0;
    expect_grant(1'b0, 1'b0, "idle0");

    // Single ALU request.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
    expect_grant(1'b1, 1'b0, "single");
    bus.alu_valid = 1'b0;
    chk("single_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    expect_grant(1'b0, 1'b0, "single_idle");
    chk("single_regwrite_off", {31'd0, bus.RegWrite}, 32'd0);
    chk("single_addr_hold", {27'd0, bus.WriteRegAddr}, 32'd5);

    // Contention: MEM wins four times, ALU the fifth, twice over.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 32'hA10;
    bus.mem_valid = 1'b1;
    m = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        bus.mem_addr = 5'(16 + (m % 8));
        bus.mem_data = 32'h100 + 32'(m);
        if (k < 4) begin
          expect_grant(1'b0, 1'b1, "contend_mem");
          m++;
        end else begin
          expect_grant(1'b1, 1'b0, "contend_alu");
          bus.alu_addr = bus.alu_addr + 5'd1;
          bus.alu_data = bus.alu_data + 32'h1;
        end
      end
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    expect_grant(1'b0, 1'b0, "idle1");

    // x0 write is accepted silently and leaves the scoreboard alone.
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd8;
    expect_grant(1'b0, 1'b0, "issue8");
    bus.issue_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h1234;
    bus.rs2_addr = 5'd8;
    expect_grant(1'b0, 1'b1, "x0");
    bus.mem_valid = 1'b0;
    chk("x0_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("x0_pending8", {31'd0, bus.rs2_pending}, 32'd1);

    // Scoreboard: set, set-beats-clear, clear, x0 never pending.
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7; bus.rs1_addr = 5'd7;
    expect_grant(1'b0, 1'b0, "issue7");
    chk("sb_set7", {31'd0, bus.rs1_pending}, 32'd1);
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
    expect_grant(1'b1, 1'b0, "sb_commit_issue");
    chk("sb_set_wins", {31'd0, bus.rs1_pending}, 32'd1);
    bus.issue_valid = 1'b0; bus.alu_data = 32'h78;
    expect_grant(1'b1, 1'b0, "sb_commit");
    chk("sb_clear7", {31'd0, bus.rs1_pending}, 32'd0);
    bus.alu_addr = 5'd8; bus.alu_data = 32'h88;
    expect_grant(1'b1, 1'b0, "sb_commit8");
    bus.alu_valid = 1'b0;
    chk("sb_clear8", {31'd0, bus.rs2_pending}, 32'd0);
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd0; bus.rs1_addr = 5'd0;
    expect_grant(1'b0, 1'b0, "issue0");
    bus.issue_valid = 1'b0;
    chk("sb_x0", {31'd0, bus.rs1_pending}, 32'd0);

    // Same destination: older load first, younger ALU value remains.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h22;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h11;
    expect_grant(1'b0, 1'b1, "samedst_mem");
    bus.mem_valid = 1'b0;
    expect_grant(1'b1, 1'b0, "samedst_alu");
    bus.alu_valid = 1'b0;
    @(negedge clk); #1;
    chk("samedst_x9", rf[9], 32'h22);
    @(posedge clk); #1;

    // Reset while a write sits in the output register drops it.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd20; bus.alu_data = 32'h55;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd21; bus.rs1_addr = 5'd21;
    expect_grant(1'b1, 1'b0, "midrst");
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    chk("midrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    chk("midrst_wr_data", bus.WriteData, 32'd0);
    chk("midrst_pending", {31'd0, bus.rs1_pending}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) expect_grant(1'b0, 1'b0, "tail");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
